// File: rtl/pms_i2c_slv_pkg.sv
// Shared definitions for the PMS I2C slave receive block: APB register map,
// FSM state encoding and status register bit positions.
package pms_i2c_slv_pkg;

  localparam logic [3:0] REG_ADDR   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_DATA   = 4'h8;
  localparam logic [3:0] REG_CTRL   = 4'hC;

  localparam int ST_BUSY_BIT = 8;
  localparam int ST_OVF_BIT  = 9;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } i2c_state_e;

endpackage

// File: rtl/pms_i2c_slv_fifo.sv
// Synchronous byte FIFO. Push while full and pop while empty are ignored;
// the head entry is visible on data_o whenever the FIFO is not empty.
module pms_i2c_slv_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pms_top_fpga_fixture.sv
// I2C slave receiver: write-only bytes addressed to R0 are ACKed and queued,
// software drains them through an APB register window with a level interrupt.
module pms_top_fpga_fixture
  import pms_i2c_slv_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus lines idle high, so the synchronizers reset to 1 to avoid false events.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_s, sda_s, scl_d_q, sda_d_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d_q    <= 1'b1;
      sda_d_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_d_q    <= scl_s;
      sda_d_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d_q;
  assign scl_fall  = ~scl_s & scl_d_q;
  assign start_det = scl_s & scl_d_q & sda_d_q & ~sda_s;
  assign stop_det  = scl_s & scl_d_q & ~sda_d_q & sda_s;

  i2c_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d, rx_byte;
  logic        sda_oe_q, sda_oe_d;
  logic        push, ovf_set;
  logic [6:0]  own_addr_q;
  logic        ien_q, ovf_q, irq_q;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [CW-1:0] fifo_count;

  assign rx_byte = {shift_q[6:0], sda_s};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sda_oe_d  = sda_oe_q;
    push      = 1'b0;
    ovf_set   = 1'b0;
    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                state_d = (rx_byte[7:1] == own_addr_q && !rx_byte[0]) ? ST_ADDR_ACK : ST_IGNORE;
              end else if (!fifo_full) begin
                push    = 1'b1;
                state_d = ST_DATA_ACK;
              end else begin
                ovf_set = 1'b1;
                state_d = ST_IGNORE;
              end
            end
          end
        end
        // First falling edge drives the ACK, the second one ends the ACK bit.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus is released combinationally so reset frees SDA in the same cycle.
  assign sda_oe_o = sda_oe_q & ~rst_i;

  logic apb_wr, apb_rd, pop, ovf_clr;
  assign apb_wr  = psel_i & penable_i & pwrite_i;
  assign apb_rd  = psel_i & penable_i & ~pwrite_i;
  assign pop     = apb_rd & (paddr_i == REG_DATA) & ~fifo_empty;
  assign ovf_clr = apb_wr & (paddr_i == REG_STATUS) & pwdata_i[ST_OVF_BIT];

  pms_i2c_slv_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (rx_byte),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      own_addr_q <= '0;
      ien_q      <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (apb_wr && paddr_i == REG_ADDR) own_addr_q <= pwdata_i[6:0];
      if (apb_wr && paddr_i == REG_CTRL) ien_q      <= pwdata_i[0];
      ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
      irq_q <= ien_q & (fifo_count != '0);
    end
  end

  logic [31:0] status;
  assign status = {22'd0, ovf_q, (state_q != ST_IDLE), 8'(fifo_count)};

  always_comb begin
    prdata_o = '0;
    if (psel_i) begin
      case (paddr_i)
        REG_ADDR:   prdata_o = {25'd0, own_addr_q};
        REG_STATUS: prdata_o = status;
        REG_DATA:   prdata_o = fifo_empty ? 32'd0 : {24'd0, fifo_head};
        REG_CTRL:   prdata_o = {31'd0, ien_q};
        default:    prdata_o = '0;
      endcase
    end
  end

  assign pready_o  = 1'b1;
  assign pslverr_o = 1'b0;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_pms_top_fpga_fixture.sv
// Directed bench for the I2C slave receiver: bit-banged master plus APB host,
// expected values written out by hand for each scenario.
module tb_pms_top_fpga_fixture;
  import pms_i2c_slv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  paddr_i = '0;
  logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [31:0] pwdata_i = '0;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o, sda_oe_o, irq_o;
  logic        scl_m = 1'b1, sda_m = 1'b1;
  logic        scl_i, sda_i;

  int   total = 0;
  int   bad = 0;
  logic oe_seen = 1'b0;

  always #5 clk = ~clk;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe_o;

  always @(posedge clk) if (sda_oe_o) oe_seen = 1'b1;

  pms_top_fpga_fixture #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .paddr_i   (paddr_i),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .pwdata_i  (pwdata_i),
    .prdata_o  (prdata_o),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe_o  (sda_oe_o),
    .irq_o     (irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic quarter();
    repeat (5) @(negedge clk);
  endtask

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    psel_i = 1'b1; pwrite_i = 1'b1; penable_i = 1'b0; paddr_i = a; pwdata_i = d;
    @(negedge clk);
    penable_i = 1'b1;
    @(negedge clk);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    psel_i = 1'b1; pwrite_i = 1'b0; penable_i = 1'b0; paddr_i = a;
    @(negedge clk);
    penable_i = 1'b1;
    #1 d = prdata_o;
    @(negedge clk);
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; quarter();
    scl_m = 1'b1; quarter();
    sda_m = 1'b0; quarter();
    scl_m = 1'b0; quarter();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; quarter();
    scl_m = 1'b1; quarter();
    sda_m = 1'b1; quarter();
  endtask

  task automatic i2c_bit(input logic b);
    sda_m = b; quarter();
    scl_m = 1'b1; quarter(); quarter();
    scl_m = 1'b0; quarter();
  endtask

  task automatic i2c_bits(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) i2c_bit(v[i]);
  endtask

  // ACK clock: sample whether the slave is pulling SDA while SCL is high.
  task automatic i2c_byte(input logic [7:0] v, output logic ack);
    i2c_bits(v);
    sda_m = 1'b1; quarter();
    scl_m = 1'b1; quarter();
    ack = sda_oe_o;
    quarter();
    scl_m = 1'b0; quarter();
  endtask

  logic [31:0] rd;
  logic        ack;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sda_oe", {31'd0, sda_oe_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    rst_i = 1'b0;
    chk("rst_prdata", prdata_o, 32'd0);
    chk("rst_state", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    apb_rd(REG_STATUS, rd); chk("rst_r1", rd, 32'd0);
    apb_rd(REG_ADDR, rd);   chk("rst_r0", rd, 32'd0);
    apb_rd(REG_CTRL, rd);   chk("rst_r3", rd, 32'd0);

    // 1: three bytes to own address
    apb_wr(REG_ADDR, 32'h50);
    apb_wr(REG_CTRL, 32'h1);
    apb_rd(REG_ADDR, rd); chk("t1_r0", rd, 32'h50);
    i2c_start();
    i2c_byte(8'hA0, ack); chk("t1_addr_ack", {31'd0, ack}, 32'd1);
    i2c_byte(8'h11, ack); chk("t1_d0_ack", {31'd0, ack}, 32'd1);
    i2c_byte(8'h22, ack); chk("t1_d1_ack", {31'd0, ack}, 32'd1);
    i2c_byte(8'h33, ack); chk("t1_d2_ack", {31'd0, ack}, 32'd1);
    chk("t1_oe_released", {31'd0, sda_oe_o}, 32'd0);
    i2c_stop();
    apb_rd(REG_STATUS, rd); chk("t1_r1", rd, 32'd3);
    chk("t1_irq", {31'd0, irq_o}, 32'd1);
    apb_rd(REG_DATA, rd); chk("t1_pop0", rd, 32'h11);
    apb_rd(REG_DATA, rd); chk("t1_pop1", rd, 32'h22);
    apb_rd(REG_DATA, rd); chk("t1_pop2", rd, 32'h33);
    @(negedge clk);
    chk("t1_irq_clr", {31'd0, irq_o}, 32'd0);

    // 2: foreign address
    oe_seen = 1'b0;
    i2c_start();
    i2c_byte(8'hA2, ack); chk("t2_nack", {31'd0, ack}, 32'd0);
    apb_rd(REG_STATUS, rd); chk("t2_busy", rd, 32'h100);
    i2c_stop();
    chk("t2_no_oe", {31'd0, oe_seen}, 32'd0);
    apb_rd(REG_STATUS, rd); chk("t2_idle", rd, 32'd0);

    // 3: read request to own address
    i2c_start();
    i2c_byte(8'hA1, ack); chk("t3_nack", {31'd0, ack}, 32'd0);
    chk("t3_ignore", {29'd0, dut.state_q}, {29'd0, ST_IGNORE});
    i2c_byte(8'h55, ack); chk("t3_nack2", {31'd0, ack}, 32'd0);
    chk("t3_ignore2", {29'd0, dut.state_q}, {29'd0, ST_IGNORE});
    i2c_stop();
    chk("t3_idle", {29'd0, dut.state_q}, {29'd0, ST_IDLE});
    apb_rd(REG_STATUS, rd); chk("t3_r1", rd, 32'd0);

    // 4: overflow with interrupts disabled
    apb_wr(REG_CTRL, 32'h0);
    i2c_start();
    i2c_byte(8'hA0, ack); chk("t4_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      i2c_byte(8'(i), ack);
      chk($sformatf("t4_ack%0d", i), {31'd0, ack}, (i < 8) ? 32'd1 : 32'd0);
    end
    i2c_stop();
    apb_rd(REG_STATUS, rd); chk("t4_r1_ovf", rd, 32'h208);
    chk("t4_irq_off", {31'd0, irq_o}, 32'd0);
    apb_wr(REG_CTRL, 32'h1);
    chk("t4_irq_lat", {31'd0, irq_o}, 32'd0);
    @(negedge clk);
    chk("t4_irq_on", {31'd0, irq_o}, 32'd1);
    apb_wr(REG_STATUS, 32'h200);
    apb_rd(REG_STATUS, rd); chk("t4_r1_clr", rd, 32'h008);
    for (int i = 0; i < 8; i++) begin
      apb_rd(REG_DATA, rd);
      chk($sformatf("t4_pop%0d", i), rd, 32'(i));
    end
    apb_rd(REG_DATA, rd); chk("t4_pop_empty", rd, 32'd0);
    apb_rd(REG_STATUS, rd); chk("t4_r1_empty", rd, 32'd0);

    // 5: repeated start in the middle of a byte
    i2c_start();
    i2c_byte(8'hA0, ack); chk("t5_addr_ack", {31'd0, ack}, 32'd1);
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1);
    i2c_start();
    i2c_byte(8'hA0, ack); chk("t5_addr2_ack", {31'd0, ack}, 32'd1);
    i2c_byte(8'h5A, ack); chk("t5_d_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    apb_rd(REG_STATUS, rd); chk("t5_r1", rd, 32'd1);
    apb_rd(REG_DATA, rd);   chk("t5_pop", rd, 32'h5A);

    // 6: reset while the slave is driving an ACK
    i2c_start();
    i2c_byte(8'hA0, ack); chk("t6_addr_ack", {31'd0, ack}, 32'd1);
    i2c_byte(8'h99, ack); chk("t6_d_ack", {31'd0, ack}, 32'd1);
    i2c_bits(8'h42);
    begin
      int n = 0;
      while (!sda_oe_o && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_oe_up", {31'd0, sda_oe_o}, 32'd1);
    rst_i = 1'b1;
    #1 chk("t6_oe_rst", {31'd0, sda_oe_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    chk("t6_oe_after", {31'd0, sda_oe_o}, 32'd0);
    chk("t6_irq", {31'd0, irq_o}, 32'd0);
    apb_rd(REG_STATUS, rd); chk("t6_r1", rd, 32'd0);
    apb_rd(REG_ADDR, rd);   chk("t6_r0", rd, 32'd0);
    apb_rd(REG_CTRL, rd);   chk("t6_r3", rd, 32'd0);
    i2c_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
